connect_win_scanner: RTL and testbench

- Sequential, parametrised successor to the combinational Score-4 win checker.
- On `start`, snapshots a COLS x ROWS board. It then walks one anchor cell per clock, testing runs of WIN_LEN in four directions.
- Reports winner, the winning run's anchor and direction, and draw detection.
- Sits between the game-control FSM and the display/score logic. The same logic is reused for larger boards and other run lengths.

---
 rtl/connect_win_scanner_if.sv | 33 +++
 rtl/connect_win_scanner.sv | 224 ++++++++++++++++++++++
 tb/tb_connect_win_scanner.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/connect_win_scanner_if.sv
// connect_win_scanner_if: request/board/result bundle between game control and the win scanner.
// Carries the board panel and every scan result; widths follow the board geometry.
interface connect_win_scanner_if #(
    parameter int unsigned COLS = 7,
    parameter int unsigned ROWS = 6
);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned NW = $clog2(COLS * ROWS * 4 + 1);

    logic                           start;
    logic                           turn;
    logic [COLS-1:0][ROWS-1:0][1:0] panel;
    logic                           busy;
    logic                           done;
    logic                           exists;
    logic                           winner;
    logic                           draw;
    logic [CW-1:0]                  win_col;
    logic [RW-1:0]                  win_row;
    logic [1:0]                     win_dir;
    logic [NW-1:0]                  win_count;

    modport master (
        output start, turn, panel,
        input  busy, done, exists, winner, draw, win_col, win_row, win_dir, win_count
    );

    modport slave (
        input  start, turn, panel,
        output busy, done, exists, winner, draw, win_col, win_row, win_dir, win_count
    );
endinterface

// File: rtl/connect_win_scanner.sv
// connect_win_scanner: walks one anchor cell per clock over a latched board, looking for WIN_LEN runs.
// Optional macro CONNECT_WIN_SCANNER_COUNT_EN: always scan the whole board and count every run.
module connect_win_scanner #(
    parameter int unsigned COLS    = 7,
    parameter int unsigned ROWS    = 6,
    parameter int unsigned WIN_LEN = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    connect_win_scanner_if.slave bus
);
    localparam int unsigned CW  = $clog2(COLS);
    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned NW  = $clog2(COLS * ROWS * 4 + 1);
    localparam int unsigned NW1 = NW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;

    state_e                         state_q, state_d;
    logic [COLS-1:0][ROWS-1:0][1:0] snap_q, snap_d;
    logic [1:0]                     player_q, player_d;
    logic [CW-1:0]                  col_q, col_d;
    logic [RW-1:0]                  row_q, row_d;
    logic                           seen_empty_q, seen_empty_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           exists_q, exists_d;
    logic                           winner_q, winner_d;
    logic                           draw_q, draw_d;
    logic [CW-1:0]                  win_col_q, win_col_d;
    logic [RW-1:0]                  win_row_q, win_row_d;
    logic [1:0]                     win_dir_q, win_dir_d;
    logic [NW-1:0]                  win_count_q, win_count_d;

    logic [3:0] hit_c;
    logic [1:0] hit_dir_c;
    logic       any_hit_c;
    logic       last_c;
    logic       cell_empty_c;
    logic       scan_end_c;

    // All four directions from the current anchor; out-of-range cells kill the run.
    always_comb begin
        int cc;
        int rr;
        cc    = 0;
        rr    = 0;
        hit_c = '1;
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < int'(WIN_LEN); k++) begin
                cc = int'(col_q) + ((d == 1) ? 0 : k);
                rr = int'(row_q) + ((d == 0) ? 0 : ((d == 3) ? -k : k));
                if (cc >= int'(COLS) || rr < 0 || rr >= int'(ROWS)) begin
                    hit_c[2'(d)] = 1'b0;
                end else if (snap_q[CW'(cc)][RW'(rr)] != player_q) begin
                    hit_c[2'(d)] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        hit_dir_c = 2'd3;
        if (hit_c[0]) begin
            hit_dir_c = 2'd0;
        end else if (hit_c[1]) begin
            hit_dir_c = 2'd1;
        end else if (hit_c[2]) begin
            hit_dir_c = 2'd2;
        end
    end

    assign any_hit_c    = |hit_c;
    assign last_c       = (col_q == CW'(COLS - 1)) && (row_q == RW'(ROWS - 1));
    assign cell_empty_c = (snap_q[col_q][row_q] == 2'b00);

`ifdef CONNECT_WIN_SCANNER_COUNT_EN
    logic [NW:0] count_sum_c;
    assign count_sum_c = {1'b0, win_count_q} + NW1'(hit_c[0]) + NW1'(hit_c[1])
                       + NW1'(hit_c[2]) + NW1'(hit_c[3]);
    assign scan_end_c  = last_c;
`else
    assign scan_end_c  = last_c | any_hit_c;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SCAN;
            SCAN:    if (scan_end_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snap_d       = snap_q;
        player_d     = player_q;
        col_d        = col_q;
        row_d        = row_q;
        seen_empty_d = seen_empty_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        exists_d     = exists_q;
        winner_d     = winner_q;
        draw_d       = draw_q;
        win_col_d    = win_col_q;
        win_row_d    = win_row_q;
        win_dir_d    = win_dir_q;
        win_count_d  = win_count_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d       = bus.panel;
                    player_d     = bus.turn ? 2'b01 : 2'b10;
                    winner_d     = ~bus.turn;
                    col_d        = '0;
                    row_d        = '0;
                    seen_empty_d = 1'b0;
                    busy_d       = 1'b1;
                    exists_d     = 1'b0;
                    draw_d       = 1'b0;
                    win_col_d    = '0;
                    win_row_d    = '0;
                    win_dir_d    = '0;
                    win_count_d  = '0;
                end
            end
            SCAN: begin
                seen_empty_d = seen_empty_q | cell_empty_c;
                if (row_q == RW'(ROWS - 1)) begin
                    row_d = '0;
                    col_d = col_q + CW'(1);
                end else begin
                    row_d = row_q + RW'(1);
                end
`ifdef CONNECT_WIN_SCANNER_COUNT_EN
                if (any_hit_c) begin
                    if (!exists_q) begin
                        win_col_d = col_q;
                        win_row_d = row_q;
                        win_dir_d = hit_dir_c;
                    end
                    exists_d    = 1'b1;
                    win_count_d = count_sum_c[NW] ? '1 : count_sum_c[NW-1:0];
                end
                if (last_c) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    draw_d = ~(exists_q | any_hit_c) & ~(seen_empty_q | cell_empty_c);
                end
`else
                if (any_hit_c) begin
                    win_col_d   = col_q;
                    win_row_d   = row_q;
                    win_dir_d   = hit_dir_c;
                    exists_d    = 1'b1;
                    win_count_d = NW'(1);
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end else if (last_c) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    draw_d = ~(seen_empty_q | cell_empty_c);
                end
`endif
            end
            DONE:    ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_q       <= '0;
            player_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            seen_empty_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            exists_q     <= 1'b0;
            winner_q     <= 1'b0;
            draw_q       <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            win_dir_q    <= '0;
            win_count_q  <= '0;
        end else begin
            snap_q       <= snap_d;
            player_q     <= player_d;
            col_q        <= col_d;
            row_q        <= row_d;
            seen_empty_q <= seen_empty_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            exists_q     <= exists_d;
            winner_q     <= winner_d;
            draw_q       <= draw_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            win_dir_q    <= win_dir_d;
            win_count_q  <= win_count_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.exists    = exists_q;
    assign bus.winner    = winner_q;
    assign bus.draw      = draw_q;
    assign bus.win_col   = win_col_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_dir   = win_dir_q;
    assign bus.win_count = win_count_q;
endmodule

// File: tb/tb_connect_win_scanner.sv
// tb_connect_win_scanner: directed and random boards on a 7x6/4 and a 9x8/5 scanner.
// Expected results come from a whole-board run search over a plain integer board.
module tb_connect_win_scanner;
    logic clk;
    logic rst_n;
    logic sel;
    int   checks;
    int   failures;
    int   brd [0:8][0:7];

    connect_win_scanner_if #(.COLS(7), .ROWS(6)) ifa ();
    connect_win_scanner_if #(.COLS(9), .ROWS(8)) ifb ();

    connect_win_scanner #(.COLS(7), .ROWS(6), .WIN_LEN(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    connect_win_scanner #(.COLS(9), .ROWS(8), .WIN_LEN(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_busy, m_done, m_exists, m_winner, m_draw, m_col, m_row, m_dir, m_count;
    always_comb begin
        if (sel) begin
            m_busy = 32'(ifb.busy);     m_done = 32'(ifb.done);       m_exists = 32'(ifb.exists);
            m_winner = 32'(ifb.winner); m_draw = 32'(ifb.draw);       m_col = 32'(ifb.win_col);
            m_row = 32'(ifb.win_row);   m_dir = 32'(ifb.win_dir);     m_count = 32'(ifb.win_count);
        end else begin
            m_busy = 32'(ifa.busy);     m_done = 32'(ifa.done);       m_exists = 32'(ifa.exists);
            m_winner = 32'(ifa.winner); m_draw = 32'(ifa.draw);       m_col = 32'(ifa.win_col);
            m_row = 32'(ifa.win_row);   m_dir = 32'(ifa.win_dir);     m_count = 32'(ifa.win_count);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, m_busy, 0);     chk({tag, "_done"}, m_done, 0);
        chk({tag, "_exists"}, m_exists, 0); chk({tag, "_winner"}, m_winner, 0);
        chk({tag, "_draw"}, m_draw, 0);     chk({tag, "_col"}, m_col, 0);
        chk({tag, "_row"}, m_row, 0);       chk({tag, "_dir"}, m_dir, 0);
        chk({tag, "_count"}, m_count, 0);
    endtask

    task automatic clear_board();
        for (int c = 0; c < 9; c++) for (int r = 0; r < 8; r++) brd[c][r] = 0;
    endtask

    task automatic load_panel(input bit s);
        for (int c = 0; c < 9; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (!s && c < 7 && r < 6) ifa.panel[3'(c)][3'(r)] = 2'(brd[c][r]);
                if (s) ifb.panel[4'(c)][3'(r)] = 2'(brd[c][r]);
            end
        end
    endtask

    task automatic rand_board(input int cols, input int rows, input int dens);
        clear_board();
        for (int c = 0; c < cols; c++) begin
            for (int r = 0; r < rows; r++) begin
                if (int'($urandom_range(0, 99)) < dens)
                    brd[c][r] = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(1, 2));
            end
        end
    endtask

    // Every (anchor, direction) pair on the board is tried; scan order fixes which one is "first".
    function automatic void model(input int cols, input int rows, input int wl, input int pl,
                                  output int ex, output int fc, output int fr, output int fd,
                                  output int cnt, output int drw, output int lat);
        int dc [4] = '{1, 0, 1, 1};
        int dr [4] = '{0, 1, 1, -1};
        bit any_empty;
        bit run;
        int x;
        int y;
        int first;
        ex = 0; fc = 0; fr = 0; fd = 0; cnt = 0; any_empty = 0; first = 0;
        for (int c = 0; c < cols; c++) begin
            for (int r = 0; r < rows; r++) begin
                if (brd[c][r] == 0) any_empty = 1;
                for (int d = 0; d < 4; d++) begin
                    run = 1;
                    for (int k = 0; k < wl; k++) begin
                        x = c + dc[d] * k;
                        y = r + dr[d] * k;
                        if (x < 0 || x >= cols || y < 0 || y >= rows) run = 0;
                        else if (brd[x][y] != pl) run = 0;
                    end
                    if (run) begin
                        cnt++;
                        if (ex == 0) begin
                            ex = 1; fc = c; fr = r; fd = d; first = c * rows + r;
                        end
                    end
                end
            end
        end
        drw = (ex == 0 && !any_empty) ? 1 : 0;
`ifdef CONNECT_WIN_SCANNER_COUNT_EN
        lat = cols * rows;
`else
        cnt = ex;
        lat = (ex != 0) ? first + 1 : cols * rows;
`endif
    endfunction

    task automatic do_scan(input bit s, input bit trn, input bit glitch, input string tag, output int n);
        int ex, fc, fr, fd, cnt, drw, lat;
        if (s) model(9, 8, 5, trn ? 1 : 2, ex, fc, fr, fd, cnt, drw, lat);
        else   model(7, 6, 4, trn ? 1 : 2, ex, fc, fr, fd, cnt, drw, lat);
        sel = s;
        @(negedge clk);
        load_panel(s);
        ifa.turn = trn; ifb.turn = trn;
        if (s) ifb.start = 1'b1; else ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0; ifb.start = 1'b0;
        ifa.panel = 84'({$urandom(), $urandom(), $urandom()});
        ifb.panel = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        chk({tag, "_busy_scan"}, m_busy, 1);
        if (glitch) begin
            ifa.turn = ~trn; ifb.turn = ~trn;
            if (s) ifb.start = 1'b1; else ifa.start = 1'b1;
        end
        n = 0;
        while (m_done !== 32'd1 && n < 200) begin
            @(negedge clk);
            n++;
            ifa.start = 1'b0; ifb.start = 1'b0;
        end
        chk({tag, "_done"}, m_done, 1);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_exists"}, m_exists, ex);
        chk({tag, "_winner"}, m_winner, 32'(!trn));
        chk({tag, "_draw"}, m_draw, drw);
        chk({tag, "_col"}, m_col, fc);
        chk({tag, "_row"}, m_row, fr);
        chk({tag, "_dir"}, m_dir, fd);
        chk({tag, "_count"}, m_count, cnt);
        @(negedge clk);
        chk({tag, "_done_pulse"}, m_done, 0);
        chk({tag, "_busy_after"}, m_busy, 0);
        chk({tag, "_exists_hold"}, m_exists, ex);
        chk({tag, "_col_hold"}, m_col, fc);
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  t;
        checks = 0; failures = 0; sel = 1'b0;
        rst_n = 1'b0;
        ifa.start = 1'b1; ifb.start = 1'b1; ifa.turn = 1'b0; ifb.turn = 1'b0;
        clear_board(); load_panel(0); load_panel(1);

        // reset with start held high
        repeat (2) @(negedge clk);
        sel = 1'b0; #1; chk_zero("rst_a");
        sel = 1'b1; #1; chk_zero("rst_b");
        ifa.start = 1'b0; ifb.start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy_b", m_busy, 0);
        sel = 1'b0; #1;
        chk("idle_busy_a", m_busy, 0);
        chk("idle_done_a", m_done, 0);

        clear_board();
        for (int c = 2; c <= 5; c++) brd[c][0] = 2;
        do_scan(0, 1'b0, 1'b0, "horiz", n);
`ifdef CONNECT_WIN_SCANNER_COUNT_EN
        chk("horiz_lat_abs", n, 42);
`else
        chk("horiz_lat_abs", n, 13);
`endif
        chk("horiz_col_abs", m_col, 2);
        chk("horiz_row_abs", m_row, 0);
        chk("horiz_dir_abs", m_dir, 0);
        chk("horiz_winner_abs", m_winner, 1);

        clear_board();
        brd[0][3] = 1; brd[1][2] = 1; brd[2][1] = 1; brd[3][0] = 1;
        for (int r = 0; r <= 3; r++) brd[6][r] = 2;
        do_scan(0, 1'b1, 1'b1, "diag", n);
        chk("diag_col_abs", m_col, 0);
        chk("diag_row_abs", m_row, 3);
        chk("diag_dir_abs", m_dir, 3);
        chk("diag_winner_abs", m_winner, 0);

        for (int c = 0; c < 7; c++) for (int r = 0; r < 6; r++) brd[c][r] = (((c + r / 2) % 2) != 0) ? 1 : 2;
        t = 1'($urandom_range(0, 1));
        do_scan(0, t, 1'b0, "draw", n);
        chk("draw_abs", m_draw, 1);
        chk("draw_lat_abs", n, 42);
        brd[6][5] = 3;
        do_scan(0, ~t, 1'b0, "draw_blocked", n);
        chk("draw_blocked_abs", m_draw, 1);
        brd[6][5] = 0;
        do_scan(0, t, 1'b0, "draw_empty", n);
        chk("draw_empty_abs", m_draw, 0);

        clear_board();
        for (int r = 3; r <= 7; r++) brd[8][r] = 2;
        do_scan(1, 1'b0, 1'b0, "vert_b", n);
        chk("vert_b_dir_abs", m_dir, 1);
        chk("vert_b_col_abs", m_col, 8);
        chk("vert_b_row_abs", m_row, 3);

        // reset in the middle of a scan on the larger board
        clear_board(); sel = 1'b1; load_panel(1); ifb.turn = 1'b0;
        @(negedge clk); ifb.start = 1'b1;
        @(negedge clk); ifb.start = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (m_done === 32'd1) seen = 1'b1;
        end
        chk("mid_busy", m_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_zero("mid_rst");
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (m_done === 32'd1 || m_busy === 32'd1) seen = 1'b1;
        end
        chk("mid_no_done", 32'(seen), 0);

        clear_board();
        for (int c = 0; c <= 4; c++) brd[c][0] = 2;
        do_scan(0, 1'b0, 1'b0, "five", n);
`ifdef CONNECT_WIN_SCANNER_COUNT_EN
        chk("five_count_abs", m_count, 2);
        chk("five_lat_abs", n, 42);
`else
        chk("five_count_abs", m_count, 1);
        chk("five_lat_abs", n, 1);
`endif
        chk("five_col_abs", m_col, 0);

        for (int i = 0; i < 40; i++) begin
            rand_board(7, 6, int'($urandom_range(20, 100)));
            do_scan(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_a", n);
        end
        for (int i = 0; i < 12; i++) begin
            rand_board(9, 8, int'($urandom_range(30, 100)));
            do_scan(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_b", n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
